// File: rtl/stall_scoreboard_controller_if.sv
`default_nettype none
// ============================================================================
// Module      : stall_scoreboard_controller_if
// Description : Issue/completion/status bundle for the stall scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
interface stall_scoreboard_controller_if #(
  parameter int MAX_PENDING = 4
) ();
  localparam int PCW = $clog2(MAX_PENDING + 1);

  logic           issue_valid;
  logic [4:0]     issue_rs1_index;
  logic [4:0]     issue_rs2_index;
  logic           issue_rs1_used;
  logic           issue_rs2_used;
  logic [4:0]     issue_rd_index;
  logic           issue_rd_write;
  logic           issue_long_latency;
  logic           complete_valid;
  logic [4:0]     complete_rd_index;
  logic           stall;
  logic           issue_accept;
  logic [31:0]    busy_vector;
  logic [PCW-1:0] pending_count;
  logic           protocol_error;
  logic           timeout_error;

  modport slave (
    input  issue_valid, issue_rs1_index, issue_rs2_index, issue_rs1_used,
           issue_rs2_used, issue_rd_index, issue_rd_write, issue_long_latency,
           complete_valid, complete_rd_index,
    output stall, issue_accept, busy_vector, pending_count,
           protocol_error, timeout_error
  );

  modport master (
    output issue_valid, issue_rs1_index, issue_rs2_index, issue_rs1_used,
           issue_rs2_used, issue_rd_index, issue_rd_write, issue_long_latency,
           complete_valid, complete_rd_index,
    input  stall, issue_accept, busy_vector, pending_count,
           protocol_error, timeout_error
  );
endinterface
`default_nettype wire

// File: rtl/stall_scoreboard_controller.sv
`default_nettype none
// ============================================================================
// Module      : stall_scoreboard_controller
// Description : Register scoreboard for long-latency writebacks; raises a
//               combinational stall on RAW/WAW/capacity hazards.
// Revision    : 1.0 - initial release
// ============================================================================
module stall_scoreboard_controller #(
  parameter int MAX_PENDING = 4,
  parameter int TIMEOUT     = 64
) (
  input  wire                             clk,
  input  wire                             reset,
  stall_scoreboard_controller_if.slave    bus
);
  localparam int PCW = $clog2(MAX_PENDING + 1);
  localparam int WDW = $clog2(TIMEOUT + 1);
  localparam logic [PCW-1:0] C_MAX_PENDING = PCW'(MAX_PENDING);
  localparam logic [WDW-1:0] C_TIMEOUT     = WDW'(TIMEOUT);

  logic [31:0]    busy_q,  busy_d;
  logic [PCW-1:0] count_q, count_d;
  logic [WDW-1:0] wd_q,    wd_d;
  logic           perr_q,  perr_d;
  logic           tout_q,  tout_d;

  logic [31:0]    w_complete_mask;
  logic [31:0]    w_eff_busy;
  logic           w_complete_hit;
  logic           w_cap_full;
  logic           w_hazard;
  logic           w_accept;
  logic           w_set;

  // A same-cycle writeback is forwarded, so its register no longer blocks.
  always_comb begin
    w_complete_mask = '0;
    if (bus.complete_valid) begin
      w_complete_mask = 32'd1 << bus.complete_rd_index;
    end
    w_eff_busy     = busy_q & ~w_complete_mask;
    w_complete_hit = bus.complete_valid && (bus.complete_rd_index != 5'd0)
                     && busy_q[bus.complete_rd_index];
    w_cap_full     = (count_q - PCW'(w_complete_hit)) == C_MAX_PENDING;

    w_hazard = (bus.issue_rs1_used && w_eff_busy[bus.issue_rs1_index])
            || (bus.issue_rs2_used && w_eff_busy[bus.issue_rs2_index])
            || (bus.issue_rd_write && w_eff_busy[bus.issue_rd_index])
            || (bus.issue_long_latency && bus.issue_rd_write && w_cap_full);

    w_accept = bus.issue_valid && !w_hazard;
    w_set    = w_accept && bus.issue_long_latency && bus.issue_rd_write
               && (bus.issue_rd_index != 5'd0);
  end

  // Set is applied after clear so a same-index set/clear leaves the bit high.
  always_comb begin
    busy_d = busy_q;
    if (w_complete_hit) begin
      busy_d[bus.complete_rd_index] = 1'b0;
    end
    if (w_set) begin
      busy_d[bus.issue_rd_index] = 1'b1;
    end
    busy_d[0] = 1'b0;

    count_d = count_q + PCW'(w_set) - PCW'(w_complete_hit);

    wd_d = wd_q;
    if ((count_q == '0) || bus.complete_valid) begin
      wd_d = '0;
    end else if (wd_q != C_TIMEOUT) begin
      wd_d = wd_q + WDW'(1);
    end

    perr_d = perr_q || (bus.complete_valid && !w_complete_hit);
    tout_d = tout_q || (wd_d == C_TIMEOUT);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_q  <= '0;
      count_q <= '0;
      wd_q    <= '0;
      perr_q  <= 1'b0;
      tout_q  <= 1'b0;
    end else begin
      busy_q  <= busy_d;
      count_q <= count_d;
      wd_q    <= wd_d;
      perr_q  <= perr_d;
      tout_q  <= tout_d;
    end
  end

  assign bus.stall          = bus.issue_valid && w_hazard;
  assign bus.issue_accept   = w_accept;
  assign bus.busy_vector    = busy_q;
  assign bus.pending_count  = count_q;
  assign bus.protocol_error = perr_q;
  assign bus.timeout_error  = tout_q;
endmodule
`default_nettype wire

// File: tb/tb_stall_scoreboard_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_stall_scoreboard_controller
// Description : Directed self-checking bench for stall_scoreboard_controller.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stall_scoreboard_controller;
  logic clk;
  logic reset;
  int   errors;
  int   checks;

  stall_scoreboard_controller_if #(.MAX_PENDING(4)) bus ();

  stall_scoreboard_controller #(
    .MAX_PENDING (4),
    .TIMEOUT     (64)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.issue_valid        = 1'b0;
    bus.issue_rs1_index    = 5'd0;
    bus.issue_rs2_index    = 5'd0;
    bus.issue_rs1_used     = 1'b0;
    bus.issue_rs2_used     = 1'b0;
    bus.issue_rd_index     = 5'd0;
    bus.issue_rd_write     = 1'b0;
    bus.issue_long_latency = 1'b0;
    bus.complete_valid     = 1'b0;
    bus.complete_rd_index  = 5'd0;
  endtask

  task automatic issue_long(input logic [4:0] rd);
    bus.issue_valid        = 1'b1;
    bus.issue_rd_index     = rd;
    bus.issue_rd_write     = 1'b1;
    bus.issue_long_latency = 1'b1;
  endtask

  task automatic complete(input logic [4:0] rd);
    bus.complete_valid    = 1'b1;
    bus.complete_rd_index = rd;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    reset  = 1'b1;
    idle();

    // Reset state; combinational issue path still live during reset
    repeat (2) @(posedge clk);
    #2;
    chk("rst_busy", bus.busy_vector, 32'h0);
    chk("rst_count", 32'(bus.pending_count), 32'd0);
    chk("rst_perr", 32'(bus.protocol_error), 32'd0);
    chk("rst_tout", 32'(bus.timeout_error), 32'd0);
    bus.issue_valid = 1'b1; bus.issue_rs1_index = 5'd5; bus.issue_rs1_used = 1'b1;
    #1;
    chk("rst_accept", 32'(bus.issue_accept), 32'd1);
    chk("rst_stall", 32'(bus.stall), 32'd0);
    idle();
    @(negedge clk);
    reset = 1'b0;

    // RAW stall released by same-cycle completion
    issue_long(5'd5);
    #1 chk("raw_issue_acc", 32'(bus.issue_accept), 32'd1);
    step(); idle();
    chk("raw_busy5", bus.busy_vector, 32'h20);
    chk("raw_count1", 32'(bus.pending_count), 32'd1);
    bus.issue_valid = 1'b1; bus.issue_rs1_index = 5'd5; bus.issue_rs1_used = 1'b1;
    bus.issue_rd_index = 5'd10; bus.issue_rd_write = 1'b1;
    #1 chk("raw_stall", 32'(bus.stall), 32'd1);
    chk("raw_noacc", 32'(bus.issue_accept), 32'd0);
    step();
    chk("raw_busy_held", bus.busy_vector, 32'h20);
    complete(5'd5);
    #1 chk("raw_fwd_stall", 32'(bus.stall), 32'd0);
    chk("raw_fwd_acc", 32'(bus.issue_accept), 32'd1);
    step(); idle();
    chk("raw_busy_clr", bus.busy_vector, 32'h0);
    chk("raw_count0", 32'(bus.pending_count), 32'd0);

    // Capacity limit and completion freeing a slot
    for (int i = 1; i <= 4; i++) begin
      idle(); issue_long(5'(i)); step();
    end
    idle();
    chk("cap_busy", bus.busy_vector, 32'h1E);
    chk("cap_count4", 32'(bus.pending_count), 32'd4);
    issue_long(5'd6);
    #1 chk("cap_stall", 32'(bus.stall), 32'd1);
    complete(5'd2);
    #1 chk("cap_free_acc", 32'(bus.issue_accept), 32'd1);
    step(); idle();
    chk("cap_busy2", bus.busy_vector, 32'h5A);
    chk("cap_count_keep", 32'(bus.pending_count), 32'd4);
    bus.issue_valid = 1'b1; bus.issue_rs2_index = 5'd4; bus.issue_rs2_used = 1'b1;
    #1 chk("rs2_stall", 32'(bus.stall), 32'd1);
    idle();
    bus.issue_valid = 1'b1; bus.issue_rs1_index = 5'd2; bus.issue_rs1_used = 1'b1;
    bus.issue_rd_index = 5'd2; bus.issue_rd_write = 1'b1;
    #1 chk("short_acc", 32'(bus.issue_accept), 32'd1);
    step(); idle();
    chk("short_nobusy", bus.busy_vector, 32'h5A);
    complete(5'd1); step();
    complete(5'd3); step();
    complete(5'd4); step();
    complete(5'd6); step(); idle();
    chk("drain_busy", bus.busy_vector, 32'h0);
    chk("drain_count", 32'(bus.pending_count), 32'd0);

    // Same-index clear and set on one edge
    issue_long(5'd7); step(); idle();
    chk("same_busy7", bus.busy_vector, 32'h80);
    complete(5'd7); issue_long(5'd7);
    #1 chk("same_acc", 32'(bus.issue_accept), 32'd1);
    step(); idle();
    chk("same_busy_kept", bus.busy_vector, 32'h80);
    chk("same_count", 32'(bus.pending_count), 32'd1);
    complete(5'd7); step(); idle();
    chk("same_drain", bus.busy_vector, 32'h0);

    // rd=0 never busy; watchdog timeout
    issue_long(5'd0);
    #1 chk("rd0_acc", 32'(bus.issue_accept), 32'd1);
    step(); idle();
    chk("rd0_busy", bus.busy_vector, 32'h0);
    chk("rd0_count", 32'(bus.pending_count), 32'd0);
    issue_long(5'd3); step(); idle();
    repeat (63) step();
    chk("wd_63", 32'(bus.timeout_error), 32'd0);
    step();
    chk("wd_64", 32'(bus.timeout_error), 32'd1);
    chk("wd_busy", bus.busy_vector, 32'h08);

    // Completion to an idle register
    complete(5'd9); step(); idle();
    chk("perr_set", 32'(bus.protocol_error), 32'd1);
    chk("perr_busy", bus.busy_vector, 32'h08);
    chk("perr_count", 32'(bus.pending_count), 32'd1);
    repeat (3) step();
    chk("perr_sticky", 32'(bus.protocol_error), 32'd1);
    chk("tout_sticky", 32'(bus.timeout_error), 32'd1);

    // Asynchronous reset mid-operation
    complete(5'd3); step(); idle();
    issue_long(5'd10); step();
    issue_long(5'd11); step();
    issue_long(5'd12); step(); idle();
    chk("pre_rst_count", 32'(bus.pending_count), 32'd3);
    #2 reset = 1'b1;
    #1;
    chk("arst_busy", bus.busy_vector, 32'h0);
    chk("arst_count", 32'(bus.pending_count), 32'd0);
    chk("arst_perr", 32'(bus.protocol_error), 32'd0);
    chk("arst_tout", 32'(bus.timeout_error), 32'd0);
    #2 reset = 1'b0;
    complete(5'd10); step(); idle();
    chk("discard_perr", 32'(bus.protocol_error), 32'd1);
    chk("discard_busy", bus.busy_vector, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/stall_scoreboard_controller.md
STALL_SCOREBOARD_CONTROLLER -- requirements
Module: stall_scoreboard_controller

Interface
REQ-001 SHALL have parameter MAX_PENDING, default 4: max outstanding long-latency writebacks.
REQ-002 SHALL have parameter TIMEOUT, default 64: watchdog limit in cycles.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port issue_valid  input  1  decode presents an instruction this cycle.
REQ-006 SHALL have ports issue_rs1_index, issue_rs2_index  input  5 each  source register indices.
REQ-007 SHALL have ports issue_rs1_used, issue_rs2_used  input  1 each  the corresponding source is read.
REQ-008 SHALL have port issue_rd_index  input  5  destination index.
REQ-009 SHALL have port issue_rd_write  input  1  the instruction writes rd.
REQ-010 SHALL have port issue_long_latency  input  1  the result comes from a multi-cycle unit (load, mul, div).
REQ-011 SHALL have ports complete_valid  input  1, and complete_rd_index  input  5  a long-latency writeback occurs this cycle.
REQ-012 SHALL have port stall  output  1  hold fetch/decode this cycle.
REQ-013 SHALL have port issue_accept  output  1  the instruction issues this cycle.
REQ-014 SHALL have port busy_vector  output  32  registered per-register pending flags.
REQ-015 SHALL have port pending_count  output  $clog2(MAX_PENDING+1)  number of set busy bits.
REQ-016 SHALL have ports protocol_error, timeout_error  output  1 each  sticky error flags.

Function
REQ-017 SHALL compute effective_busy = busy_vector with bit complete_rd_index cleared when complete_valid=1; the same-cycle writeback is forwarded by the forward unit.
REQ-018 SHALL raise hazard if any of: rs1_used & effective_busy[rs1]; rs2_used & effective_busy[rs2]; rd_write & effective_busy[rd] (WAW); issue_long_latency & rd_write & (pending_count - completing) == MAX_PENDING.
REQ-019 SHALL treat index 0 as never busy and never set busy_vector[0].
REQ-020 SHALL drive stall = issue_valid & hazard and issue_accept = issue_valid & ~hazard, both combinational, with zero-cycle latency.
REQ-021 SHALL, on an edge with issue_accept & issue_long_latency & issue_rd_write & rd!=0, set busy_vector[rd].
REQ-022 SHALL, on an edge with complete_valid & busy_vector[complete_rd_index], clear that bit.
REQ-023 SHALL, when a set and a clear target the same index on the same edge, apply the set (the bit stays 1).
REQ-024 SHALL update pending_count by +1 per set and -1 per clear; a simultaneous set and clear leave it unchanged; it SHALL always equal popcount(busy_vector).
REQ-025 SHALL, on complete_valid with busy_vector[complete_rd_index]=0 or complete_rd_index=0, leave state unchanged and set protocol_error.
REQ-026 SHALL keep a watchdog counter, cleared when pending_count==0 or complete_valid=1, otherwise incremented each cycle, saturating at TIMEOUT.
REQ-027 SHALL set timeout_error on the edge where the watchdog reaches TIMEOUT.
REQ-028 SHALL clear protocol_error and timeout_error only by reset.
REQ-029 SHALL issue short-latency instructions (issue_long_latency=0) without touching the scoreboard.

Reset
REQ-030 SHALL, while reset=1, immediately force busy_vector=0, pending_count=0, the watchdog to 0, protocol_error=0 and timeout_error=0; stall and issue_accept SHALL then follow REQ-020 with an empty scoreboard.
REQ-031 SHALL discard all pending entries on reset asserted mid-operation; a later completion for a discarded entry SHALL set protocol_error.

Verification
REQ-032 Scenario: issue long rd=5; next cycle issue rs1=5 used -> stall=1, issue_accept=0; on complete_valid rd=5, that same cycle stall=0, issue_accept=1; busy_vector[5]=0 after the edge.
REQ-033 Scenario: issue 4 long ops rd=1..4; 5th long op rd=6 -> stall=1, pending_count=4; completing rd=2 in that cycle -> 5th accepted, pending_count stays 4.
REQ-034 Scenario: busy[7]=1; same cycle complete rd=7 and issue long rd=7 -> accepted, busy[7]=1, pending_count unchanged.
REQ-035 Scenario: complete_valid rd=9 with busy[9]=0 -> protocol_error=1, busy_vector unchanged; error persists until reset.
REQ-036 Scenario: issue long rd=3, no completion for 64 cycles -> timeout_error=1 at cycle 64; a long op with rd=0 -> busy_vector stays 0.
REQ-037 Scenario: assert reset asynchronously with pending_count=3 -> all outputs zero before the next clk edge.
